// File: rtl/down_sign.sv
// Downlink frame decoder: parses EB 90 <type> <hi> <lo> <sum> byte frames into per-type
// strobes and a 16-bit payload, flagging bad checksums, illegal types and stalled frames.
module down_sign #(
  parameter logic [15:0] TIMEOUT = 16'd5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        fault_en,
  output logic        volt_en,
  output logic        state_en,
  output logic        fre_en,
  output logic [15:0] rx_word,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr2,
    StType,
    StDHi,
    StDLo,
    StSum
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  type_q, type_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [3:0]  strobe_q, strobe_d;  // {fault, volt, state, fre}
  logic        err_q, err_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  sum;
  logic        timeout;

  assign sum = type_q + hi_q + lo_q;

  // Fires in the cycle the counter reaches TIMEOUT; an arriving byte takes priority.
  assign timeout = (state_q != StIdle) && !rx_valid && (cnt_q == TIMEOUT - 16'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    strobe_d = 4'b0000;
    err_d    = 1'b0;
    word_d   = word_q;

    if (rx_valid) begin
      cnt_d = 16'd0;
      unique case (state_q)
        StIdle: begin
          if (rx_data == 8'hEB) state_d = StHdr2;
        end
        StHdr2: begin
          if (rx_data == 8'h90) begin
            state_d = StType;
          end else if (rx_data != 8'hEB) begin
            state_d = StIdle;
          end
        end
        StType: begin
          if (rx_data >= 8'h01 && rx_data <= 8'h04) begin
            type_d  = rx_data;
            state_d = StDHi;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        StDHi: begin
          hi_d    = rx_data;
          state_d = StDLo;
        end
        StDLo: begin
          lo_d    = rx_data;
          state_d = StSum;
        end
        StSum: begin
          state_d = StIdle;
          if (sum == rx_data) begin
            word_d = {hi_q, lo_q};
            unique case (type_q)
              8'h01:   strobe_d = 4'b1000;
              8'h02:   strobe_d = 4'b0100;
              8'h03:   strobe_d = 4'b0010;
              default: strobe_d = 4'b0001;
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q == StIdle) begin
      cnt_d = 16'd0;
    end else if (timeout) begin
      err_d   = 1'b1;
      state_d = StIdle;
      cnt_d   = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 16'd0;
      type_q   <= 8'h00;
      hi_q     <= 8'h00;
      lo_q     <= 8'h00;
      strobe_q <= 4'b0000;
      err_q    <= 1'b0;
      word_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
      word_q   <= word_d;
    end
  end

  assign fault_en  = strobe_q[3];
  assign volt_en   = strobe_q[2];
  assign state_en  = strobe_q[1];
  assign fre_en    = strobe_q[0];
  assign frame_err = err_q;
  assign rx_word   = word_q;

endmodule

// File: doc/down_sign.md
# down_sign

Downlink frame decoder that sits behind the byte-level serial receiver and forms the receiving end of the unit's framed status link. It parses byte frames of the form header 0xEB 0x90, type, data high, data low, checksum. For each valid frame it emits a one-cycle strobe for the decoded type (fault, volt, state, fre) and presents the 16-bit payload. Malformed, corrupted or stalled frames are dropped and flagged with an error pulse.

## Interface

- TIMEOUT, 16'd5000: maximum idle gap in clk cycles between bytes inside a frame.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_valid is high.
- rx_valid  in  1  one-cycle byte strobe from the serial receiver. It is never high on consecutive cycles faster than the serial rate, but the block must tolerate back-to-back strobes.
- fault_en  out  1  one-cycle strobe: valid frame with type 0x01.
- volt_en  out  1  one-cycle strobe: valid frame with type 0x02.
- state_en  out  1  one-cycle strobe: valid frame with type 0x03.
- fre_en  out  1  one-cycle strobe: valid frame with type 0x04.
- rx_word  out  16  payload of the last valid frame, {data_hi, data_lo}. Held until the next valid frame.
- frame_err  out  1  one-cycle strobe on checksum error, illegal type, or timeout.

## Operation

- States:
  - IDLE: waiting for 0xEB.
  - HDR2: expecting 0x90.
  - TYPE: expecting the type byte.
  - D_HI: expecting the data high byte.
  - D_LO: expecting the data low byte.
  - SUM: expecting the checksum byte.
- State transitions happen only on cycles with rx_valid=1, with one exception: a timeout.
- IDLE: byte 0xEB goes to HDR2. Any other byte is ignored with no error.
- HDR2:
  - 0x90 goes to TYPE.
  - 0xEB stays in HDR2, which resyncs on a repeated header.
  - Any other byte goes to IDLE with no error.
- TYPE:
  - Bytes 0x01 to 0x04 are latched and go to D_HI.
  - Any other byte pulses frame_err and goes to IDLE.
- D_HI: byte is latched, go to D_LO.
- D_LO: byte is latched, go to SUM.
- SUM: compute (type + data_hi + data_lo) mod 256 as an 8-bit sum with the carry discarded.
  - Equal to the checksum byte: pulse the strobe for the latched type, update rx_word, go to IDLE.
  - Not equal: pulse frame_err, rx_word unchanged, go to IDLE.
- Timeout counter (16 bit):
  - Cleared on every rx_valid and held at 0 while in IDLE.
  - Increments every cycle in any other state.
  - On reaching TIMEOUT: pulse frame_err, go to IDLE, clear the counter.
  - If rx_valid arrives in the same cycle the counter reaches TIMEOUT, the byte wins: it is processed normally and no timeout fires.
- At most one of fault_en, volt_en, state_en, fre_en and frame_err is high in any cycle.
- Reset mid-frame: the partial frame is discarded with no error pulse, and the FSM returns to IDLE.

## Timing

- Reset values:
  - Outputs: fault_en, volt_en, state_en, fre_en and frame_err = 0; rx_word = 16'h0000.
  - Internal: state = IDLE, counter = 0.
- All outputs are registered.
- A strobe or frame_err goes high in cycle N+1, where N is the rx_valid cycle of the deciding byte, and lasts exactly 1 cycle.
- rx_word changes in the same cycle its type strobe rises.
- Timeout error: frame_err goes high TIMEOUT+1 cycles after the last in-frame rx_valid.
- Back-to-back frames with no gap between the checksum byte and the next 0xEB are fully decoded.
- The checksum adder and comparator are a single combinational level feeding registered outputs. There is no pipelining.

## Test plan

- Volt frame:
  - Stimulus: EB 90 02 03 E8 ED (checksum 0x02+0x03+0xE8 = 0xED).
  - Required response: volt_en pulses 1 cycle after the ED strobe, rx_word = 16'h03E8, frame_err stays 0.
- All four types back-to-back:
  - Stimulus: types 01/02/03/04 with data 0x1234 and checksums 47/48/49/4A, no gaps.
  - Required response: fault_en, volt_en, state_en and fre_en pulse in order, rx_word = 16'h1234 each time, no other strobes.
- Checksum error:
  - Stimulus: EB 90 03 00 10 00.
  - Required response: frame_err pulses once, state_en stays 0, rx_word keeps its previous value.
- Illegal type and resync:
  - Stimulus: EB 90 07, then EB EB 90 04 00 01 05.
  - Required response: frame_err pulses after 07; fre_en then pulses with rx_word = 16'h0001.
- Timeout:
  - Stimulus: TIMEOUT=20, send EB 90 01 and stop.
  - Required response: frame_err high exactly 21 cycles after the 01 strobe. A following complete fault frame then decodes normally.
  - Also drive a byte on exactly the 20th idle cycle and check that no timeout fires.
- Reset mid-frame:
  - Stimulus: assert rst for 1 cycle after EB 90 02 03, then send E8 ED.
  - Required response: no strobe, no frame_err, all outputs at reset values.
